// File: rtl/td4_pkg.sv
// Shared types and opcode constants for the TD4 sequencer and its decoder.
package td4_pkg;

   localparam logic [3:0] OP_ADD_A   = 4'b0000;
   localparam logic [3:0] OP_MOV_AB  = 4'b0001;
   localparam logic [3:0] OP_IN_A    = 4'b0010;
   localparam logic [3:0] OP_MOV_A   = 4'b0011;
   localparam logic [3:0] OP_MOV_BA  = 4'b0100;
   localparam logic [3:0] OP_ADD_B   = 4'b0101;
   localparam logic [3:0] OP_IN_B    = 4'b0110;
   localparam logic [3:0] OP_MOV_B   = 4'b0111;
   localparam logic [3:0] OP_OUT_B   = 4'b1001;
   localparam logic [3:0] OP_OUT_IM  = 4'b1011;
   localparam logic [3:0] OP_JNC     = 4'b1110;
   localparam logic [3:0] OP_JMP     = 4'b1111;

   typedef enum logic [1:0] {FETCH, EXEC, PCINC} state_t;

   typedef enum logic [1:0] {SEL_A, SEL_B, SEL_IN, SEL_ZERO} sel_t;

   typedef enum logic [2:0] {DST_A, DST_B, DST_OUT, DST_PC, DST_NONE} dst_t;

endpackage

// File: rtl/td4_decode.sv
// Opcode decoder: picks the adder's A operand, whether Im feeds the B operand,
// the write destination, and whether a jump is taken.
module td4_decode
   import td4_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       carry,
   output sel_t       sel,
   output logic       im_en,
   output dst_t       dst,
   output logic       jump_taken
);

   always_comb begin
      sel        = SEL_ZERO;
      im_en      = 1'b0;
      dst        = DST_NONE;
      jump_taken = 1'b0;
      case (opcode)
         OP_ADD_A:  begin sel = SEL_A;  im_en = 1'b1; dst = DST_A;   end
         OP_ADD_B:  begin sel = SEL_B;  im_en = 1'b1; dst = DST_B;   end
         OP_MOV_A:  begin               im_en = 1'b1; dst = DST_A;   end
         OP_MOV_B:  begin               im_en = 1'b1; dst = DST_B;   end
         OP_MOV_AB: begin sel = SEL_B;                dst = DST_A;   end
         OP_MOV_BA: begin sel = SEL_A;                dst = DST_B;   end
         OP_IN_A:   begin sel = SEL_IN;               dst = DST_A;   end
         OP_IN_B:   begin sel = SEL_IN;               dst = DST_B;   end
         OP_OUT_B:  begin sel = SEL_B;                dst = DST_OUT; end
         OP_OUT_IM: begin               im_en = 1'b1; dst = DST_OUT; end
         OP_JMP:    begin               im_en = 1'b1; dst = DST_PC; jump_taken = 1'b1; end
         // JNC looks at the flag as it stood before this EXEC rewrites it
         OP_JNC: begin
            im_en = 1'b1;
            if (!carry) begin
               dst        = DST_PC;
               jump_taken = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control unit: owns the architectural registers and time-shares one
// external 4-bit adder between instruction execution and PC increment.
//
//   state | meaning
//   FETCH | adder idle; latch IR from ROM when step_en is high
//   EXEC  | adder computes the instruction result; C <- carry out
//   PCINC | adder computes PC + 1; C untouched
module td4_sequencer
   import td4_pkg::*;
(
   input  logic       clk,
   input  logic       n_reset,
   input  logic       step_en,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [3:0] in_port,
   output logic [3:0] out_port,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   output logic       add_cin,
   input  logic [3:0] add_s,
   input  logic       add_cout,
   output logic [3:0] reg_a,
   output logic [3:0] reg_b,
   output logic       carry,
   output logic       instr_done
);

   state_t     state_q, state_d;
   logic [7:0] ir_q;
   logic [3:0] pc_q, a_q, b_q, out_q;
   logic       c_q, done_q;

   sel_t       sel;
   logic       im_en;
   dst_t       dst;
   logic       jump_taken;

   td4_decode u_decode (
      .opcode     (ir_q[7:4]),
      .carry      (c_q),
      .sel        (sel),
      .im_en      (im_en),
      .dst        (dst),
      .jump_taken (jump_taken)
   );

   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      state_d = state_q;
      case (state_q)
         FETCH: if (step_en) state_d = EXEC;
         EXEC: begin
            case (sel)
               SEL_A:   add_a = a_q;
               SEL_B:   add_a = b_q;
               SEL_IN:  add_a = in_port;
               default: add_a = 4'd0;
            endcase
            add_b   = im_en ? ir_q[3:0] : 4'd0;
            state_d = jump_taken ? FETCH : PCINC;
         end
         PCINC: begin
            add_a   = pc_q;
            add_cin = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= FETCH;
         ir_q    <= 8'd0;
         pc_q    <= 4'd0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         out_q   <= 4'd0;
         c_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == PCINC) || ((state_q == EXEC) && jump_taken);
         case (state_q)
            FETCH: if (step_en) ir_q <= rom_data;
            EXEC: begin
               c_q <= add_cout;
               case (dst)
                  DST_A:   a_q   <= add_s;
                  DST_B:   b_q   <= add_s;
                  DST_OUT: out_q <= add_s;
                  DST_PC:  pc_q  <= add_s;
                  default: ;
               endcase
            end
            PCINC: pc_q <= add_s;
            default: ;
         endcase
      end
   end

   assign rom_addr   = pc_q;
   assign out_port   = out_q;
   assign reg_a      = a_q;
   assign reg_b      = b_q;
   assign carry      = c_q;
   assign instr_done = done_q;

endmodule

// File: doc/td4_sequencer.md
# td4_sequencer

Multi-cycle control unit for the TD4 4-bit CPU. It owns the architectural registers (A, B, OUT, PC, carry flag, instruction register) and schedules a single external IC74HC283 4-bit adder between instruction execution and PC increment. It sits between the 16×8 program ROM, the I/O ports and the adder instance, and sequences every instruction as FETCH → EXEC → PCINC.

## Interface
- No parameters. Widths are fixed by the TD4 ISA: 4-bit data, 4-bit address, 8-bit instruction.
- `clk` in 1: single clock. All state updates on the rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `step_en` in 1: permits leaving FETCH. Ignored in other states.
- `rom_addr` out 4: equals PC.
- `rom_data` in 8: combinational ROM output. `[7:4]` is the opcode, `[3:0]` is Im.
- `in_port` in 4: input port, sampled in EXEC.
- `out_port` out 4: OUT register.
- `add_a`, `add_b` out 4: adder operands.
- `add_cin` out 1: adder carry-in.
- `add_s` in 4: adder sum.
- `add_cout` in 1: adder carry-out. The adder is combinational; its result is sampled the same cycle.
- `reg_a`, `reg_b` out 4: A and B registers (debug/observation).
- `carry` out 1: C flag.
- `instr_done` out 1: one-cycle pulse in the cycle after an instruction retires.

## Operation
- States: FETCH, EXEC, PCINC.
- **FETCH**
  - Adder inputs are all 0.
  - If `step_en`=1: IR ← `rom_data`, go to EXEC.
  - Otherwise hold.
- **EXEC**
  - `add_cin`=0. `add_a`/`add_b` are selected by opcode:
  - 0000 ADD A,Im: A + Im → A
  - 0101 ADD B,Im: B + Im → B
  - 0011 MOV A,Im: 0 + Im → A
  - 0111 MOV B,Im: 0 + Im → B
  - 0001 MOV A,B: B + 0 → A
  - 0100 MOV B,A: A + 0 → B
  - 0010 IN A: in_port + 0 → A
  - 0110 IN B: in_port + 0 → B
  - 1001 OUT B: B + 0 → OUT
  - 1011 OUT Im: 0 + Im → OUT
  - 1111 JMP Im: 0 + Im, taken
  - 1110 JNC Im: 0 + Im, taken iff C=0, evaluated using C *before* this EXEC's update
  - Any other opcode: NOP, 0 + 0, no write.
  - Every EXEC, including jumps and NOPs, writes C ← `add_cout`. Jumps and NOPs therefore clear C.
  - Taken jump: PC ← `add_s`, go to FETCH.
  - Otherwise go to PCINC.
- **PCINC**
  - Drive `add_a`=PC, `add_b`=0, `add_cin`=1.
  - PC ← `add_s`. Wrap 15 → 0; `add_cout` is ignored and C is unchanged.
  - Go to FETCH.
- `instr_done` is registered. It is set on the transition into FETCH from EXEC (taken jump) or from PCINC, and cleared the next cycle.
- Sums wrap modulo 16. The carry out of an ADD lands in C.

## Timing
- **Reset** (async assert, sync-safe deassert as an async flop):
  - State=FETCH
  - PC, A, B, OUT, C, IR = 0
  - `instr_done`=0
  - `add_a`, `add_b`, `add_cin` = 0 (combinational from state FETCH)
- **Latency**, counted from the `step_en` edge in FETCH:
  - Non-jump and not-taken JNC: 3 cycles. Destination register and C are visible after EXEC; the PC update is visible after PCINC.
  - Taken JMP/JNC: 2 cycles.
- `step_en` held high gives back-to-back instructions with no bubble beyond the FETCH cycle.
- `rom_addr` changes only on the PCINC edge or the taken-jump edge.
- Reset asserted mid-instruction: immediate return to reset values. The partial instruction has no effect beyond writes already committed.
- Adder ownership is exclusive by state. Adder outputs are a pure function of (state, IR, A, B, PC, `in_port`).

## Structure
- **Package `td4_pkg`:**
  - 4-bit opcode localparams (OP_ADD_A, …, OP_JNC, OP_JMP)
  - state enum {FETCH, EXEC, PCINC}
  - operand-select enum {SEL_A, SEL_B, SEL_IN, SEL_ZERO}
  - destination enum {DST_A, DST_B, DST_OUT, DST_PC, DST_NONE}
- **Sub-module `td4_decode`:** combinational. Maps opcode and C to operand select, destination and jump-taken.
- **Adder:** not inside this block. The top level instantiates IC74HC283 and wires it to the `add_*` ports. The bench does the same.

## Test plan
- **Reset/idle:** assert `n_reset`=0 mid-EXEC, then hold `step_en`=0 → all outputs 0, `rom_addr` stays 0, no `instr_done`.
- **MOV/ADD carry:** ROM runs MOV A,15 then ADD A,1 → A=0, C=1 after the second EXEC. The next instruction JNC 5 is not taken, and C is cleared by that EXEC.
- **JNC taken:** ADD B,1 with B=3 (C←0), then JNC 9 → PC=9 two cycles after the JNC fetch, with no PCINC state visited.
- **Wrap:** PC=15 with a non-jump instruction → `rom_addr`=0 after PCINC, and C is unaffected by the PCINC carry.
- **I/O:** `in_port`=4'b1010, IN A, OUT B after MOV B,A → `out_port`=1010.
- **Stall:** toggle `step_en` low for 5 cycles between instructions → state holds FETCH, registers are stable, and `instr_done` pulses exactly once per instruction.
